// File: rtl/pipe_pkg.sv
// Shared types and default widths for the fetch/decode skid stage.
// Optional perf counters are enabled with PIPE_STAGE_PERF_EN.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_e;

  localparam int DEF_PC_W    = 64;
  localparam int DEF_INSTR_W = 32;
  localparam int DEF_CI_W    = 161;

  localparam int DEF_LANE_W = DEF_PC_W + DEF_INSTR_W + DEF_CI_W;

endpackage

// File: rtl/pipe_stage_skid_reg_pipe_payload_slot.sv
// One payload register: clear wins over load, async active-high reset.
module pipe_payload_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         clear_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (clear_i)
      data_d = '0;
    else if (load_i)
      data_d = d_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      data_q <= '0;
    else
      data_q <= data_d;
  end

  assign q_o = data_q;

endmodule

// File: rtl/pipe_stage_skid_reg.sv
// Two-entry skid stage register; in_ready comes straight from state.
// Define PIPE_STAGE_PERF_EN to add stall / flush-drop counters.
module pipe_stage_skid_reg
  import pipe_pkg::*;
#(
  parameter int LANES   = 1,
  parameter int PC_W    = DEF_PC_W,
  parameter int INSTR_W = DEF_INSTR_W,
  parameter int CI_W    = DEF_CI_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*PC_W-1:0]    in_pc,
  input  logic [LANES*INSTR_W-1:0] in_instr,
  input  logic [LANES*CI_W-1:0]    in_commit_info,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES*PC_W-1:0]    out_pc,
  output logic [LANES*INSTR_W-1:0] out_instr,
  output logic [LANES*CI_W-1:0]    out_commit_info
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]           perf_stall_cnt,
  output logic [31:0]           perf_flush_drop_cnt
`endif
);

  localparam int PCB = LANES * PC_W;
  localparam int INB = LANES * INSTR_W;
  localparam int CIB = LANES * CI_W;
  localparam int PW  = PCB + INB + CIB;

  pipe_state_e state_q, state_d;

  logic [PW-1:0] in_pl;
  logic [PW-1:0] main_q;
  logic [PW-1:0] skid_q;
  logic [PW-1:0] main_in;

  logic main_ld, main_clr, main_from_skid;
  logic skid_ld, skid_clr;
  logic fire_in, fire_out;

  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);

  assign fire_in  = in_valid & in_ready;
  assign fire_out = out_valid & out_ready;

  assign in_pl = {in_commit_info, in_instr, in_pc};

  always_comb begin
    state_d        = state_q;
    main_ld        = 1'b0;
    main_clr       = 1'b0;
    main_from_skid = 1'b0;
    skid_ld        = 1'b0;
    skid_clr       = 1'b0;
    if (flush) begin
      state_d  = EMPTY;
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (fire_in) begin
            main_ld = 1'b1;
            state_d = ONE;
          end
        end
        ONE: begin
          if (fire_in && fire_out) begin
            main_ld = 1'b1;
          end else if (fire_out) begin
            main_clr = 1'b1;
            state_d  = EMPTY;
          end else if (fire_in) begin
            skid_ld = 1'b1;
            state_d = TWO;
          end
        end
        TWO: begin
          if (out_ready) begin
            main_ld        = 1'b1;
            main_from_skid = 1'b1;
            skid_clr       = 1'b1;
            state_d        = ONE;
          end
        end
        default: begin
          state_d  = EMPTY;
          main_clr = 1'b1;
          skid_clr = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= EMPTY;
    else
      state_q <= state_d;
  end

  assign main_in = main_from_skid ? skid_q : in_pl;

  pipe_payload_slot #(.W(PW)) u_main (
    .clk     (clk),
    .rst     (rst),
    .load_i  (main_ld),
    .clear_i (main_clr),
    .d_i     (main_in),
    .q_o     (main_q)
  );

  pipe_payload_slot #(.W(PW)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .load_i  (skid_ld),
    .clear_i (skid_clr),
    .d_i     (in_pl),
    .q_o     (skid_q)
  );

  assign out_pc          = main_q[PCB-1:0];
  assign out_instr       = main_q[PCB+INB-1:PCB];
  assign out_commit_info = main_q[PW-1:PCB+INB];

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_q, stall_d;
  logic [31:0] drop_q, drop_d;
  logic [1:0]  held;
  logic [1:0]  drop_add;
  logic [32:0] drop_sum;

  always_comb begin
    held = 2'd0;
    if (state_q == ONE)
      held = 2'd1;
    else if (state_q == TWO)
      held = 2'd2;
  end

  assign drop_add = held + {1'b0, in_valid};
  assign drop_sum = {1'b0, drop_q} + {31'd0, drop_add};

  always_comb begin
    stall_d = stall_q;
    drop_d  = drop_q;
    if (out_valid && !out_ready && stall_q != 32'hFFFF_FFFF)
      stall_d = stall_q + 32'd1;
    if (flush)
      drop_d = drop_sum[32] ? 32'hFFFF_FFFF : drop_sum[31:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      drop_q  <= '0;
    end else begin
      stall_q <= stall_d;
      drop_q  <= drop_d;
    end
  end

  assign perf_stall_cnt      = stall_q;
  assign perf_flush_drop_cnt = drop_q;
`endif

endmodule
